// File: rtl/axi_mem_responder_if.sv
`default_nettype none
// =============================================================================
// Module   : axi_mem_responder_if
// Brief    : AXI4 channel bundle between the core initiator and the memory responder.
// Revision : 1.0 - initial release
// =============================================================================
interface axi_mem_responder_if #(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic                    aw_valid_i;
   logic                    aw_ready_o;
   logic [ID_WIDTH-1:0]     aw_id_i;
   logic [ADDR_WIDTH-1:0]   aw_addr_i;
   logic [7:0]              aw_len_i;
   logic [2:0]              aw_size_i;
   logic [1:0]              aw_burst_i;

   logic                    w_valid_i;
   logic                    w_ready_o;
   logic [DATA_WIDTH-1:0]   w_data_i;
   logic [DATA_WIDTH/8-1:0] w_strb_i;
   logic                    w_last_i;

   logic                    b_valid_o;
   logic                    b_ready_i;
   logic [ID_WIDTH-1:0]     b_id_o;
   logic [1:0]              b_resp_o;

   logic                    ar_valid_i;
   logic                    ar_ready_o;
   logic [ID_WIDTH-1:0]     ar_id_i;
   logic [ADDR_WIDTH-1:0]   ar_addr_i;
   logic [7:0]              ar_len_i;
   logic [2:0]              ar_size_i;
   logic [1:0]              ar_burst_i;

   logic                    r_valid_o;
   logic                    r_ready_i;
   logic [ID_WIDTH-1:0]     r_id_o;
   logic [DATA_WIDTH-1:0]   r_data_o;
   logic [1:0]              r_resp_o;
   logic                    r_last_o;

   modport slave (
      input  aw_valid_i, aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i,
      output aw_ready_o,
      input  w_valid_i, w_data_i, w_strb_i, w_last_i,
      output w_ready_o,
      input  b_ready_i,
      output b_valid_o, b_id_o, b_resp_o,
      input  ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
      output ar_ready_o,
      input  r_ready_i,
      output r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
   );

   modport master (
      output aw_valid_i, aw_id_i, aw_addr_i, aw_len_i, aw_size_i, aw_burst_i,
      input  aw_ready_o,
      output w_valid_i, w_data_i, w_strb_i, w_last_i,
      input  w_ready_o,
      output b_ready_i,
      input  b_valid_o, b_id_o, b_resp_o,
      output ar_valid_i, ar_id_i, ar_addr_i, ar_len_i, ar_size_i, ar_burst_i,
      input  ar_ready_o,
      output r_ready_i,
      input  r_valid_o, r_id_o, r_data_o, r_resp_o, r_last_o
   );
endinterface
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// =============================================================================
// Module   : axi_mem_responder
// Brief    : AXI4 responder serving one read or write burst at a time from a word memory.
// Revision : 1.0 - initial release
// =============================================================================
module axi_mem_responder #(
   parameter int                    ID_WIDTH   = 4,
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 64,
   parameter int                    DEPTH      = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000
) (
   input  wire logic          clk_i,
   input  wire logic          rst_ni,
   axi_mem_responder_if.slave bus
);
   localparam int                    c_IDX_W    = $clog2(DEPTH);
   localparam int                    c_LANES    = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] c_END_ADDR = BASE_ADDR + ADDR_WIDTH'(DEPTH * 8);
   localparam logic [1:0]            c_RESP_OKAY   = 2'b00;
   localparam logic [1:0]            c_RESP_SLVERR = 2'b10;
   localparam logic [1:0]            c_RESP_DECERR = 2'b11;
   localparam logic [1:0]            c_BURST_FIXED = 2'b00;
   localparam logic [1:0]            c_BURST_INCR  = 2'b01;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RD    = 2'd1,
      S_WR    = 2'd2,
      S_WRESP = 2'd3
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic                    r_prio_rd;
   logic [ID_WIDTH-1:0]     r_id;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [7:0]              r_len, r_cnt;
   logic [2:0]              r_size;
   logic [1:0]              r_burst;
   logic [1:0]              r_err;
   logic                    r_rvalid, r_rlast;
   logic [1:0]              r_rresp;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

   logic                    w_ar_grant, w_aw_grant, w_w_ready, w_b_valid;
   logic                    w_r_hs, w_w_hs, w_last_beat, w_in_range, w_burst_ok, w_mem_we;
   logic [ADDR_WIDTH-1:0]   w_next_addr, w_beat_addr, w_off;
   logic [7:0]              w_beat_cnt;
   logic [c_IDX_W-1:0]      w_idx;
   logic [1:0]              w_beat_resp, w_wr_resp;

   assign w_next_addr = (r_burst == c_BURST_FIXED) ? r_addr
                                                   : r_addr + (ADDR_WIDTH'(1) << r_size);
   assign w_r_hs      = r_rvalid && bus.r_ready_i;
   assign w_w_hs      = w_w_ready && bus.w_valid_i;
   assign w_last_beat = (r_cnt == r_len);

   // On a read handshake the next beat is fetched in the same edge, so look ahead.
   assign w_beat_addr = w_r_hs ? w_next_addr : r_addr;
   assign w_beat_cnt  = w_r_hs ? r_cnt + 8'd1 : r_cnt;
   assign w_off       = w_beat_addr - BASE_ADDR;
   assign w_idx       = c_IDX_W'(w_off >> 3);
   assign w_in_range  = (w_beat_addr >= BASE_ADDR) && (w_beat_addr < c_END_ADDR);
   assign w_burst_ok  = (r_burst == c_BURST_INCR) || (r_burst == c_BURST_FIXED);
   assign w_mem_we    = w_w_hs && (w_beat_resp == c_RESP_OKAY);

   always_comb begin
      w_beat_resp = c_RESP_OKAY;
      if (!w_in_range) begin
         w_beat_resp = c_RESP_DECERR;
      end else if (!w_burst_ok) begin
         w_beat_resp = c_RESP_SLVERR;
      end
      w_wr_resp = w_beat_resp;
      if ((bus.w_last_i != w_last_beat) && (w_beat_resp == c_RESP_OKAY)) begin
         w_wr_resp = c_RESP_SLVERR;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_ar_grant  = 1'b0;
      w_aw_grant  = 1'b0;
      w_w_ready   = 1'b0;
      w_b_valid   = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ar_grant = rst_ni && bus.ar_valid_i && (!bus.aw_valid_i || r_prio_rd);
            w_aw_grant = rst_ni && bus.aw_valid_i && (!bus.ar_valid_i || !r_prio_rd);
            if (w_ar_grant) begin
               w_state_nxt = S_RD;
            end else if (w_aw_grant) begin
               w_state_nxt = S_WR;
            end
         end
         S_RD: begin
            if (w_r_hs && r_rlast) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WR: begin
            w_w_ready = 1'b1;
            if (bus.w_valid_i && w_last_beat) begin
               w_state_nxt = S_WRESP;
            end
         end
         S_WRESP: begin
            w_b_valid = 1'b1;
            if (bus.b_ready_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_prio_rd <= 1'b1;
         r_id      <= '0;
         r_addr    <= '0;
         r_len     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_cnt     <= '0;
         r_err     <= c_RESP_OKAY;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rresp   <= c_RESP_OKAY;
         r_rdata   <= '0;
      end else begin
         if (w_ar_grant) begin
            r_id    <= bus.ar_id_i;
            r_addr  <= bus.ar_addr_i;
            r_len   <= bus.ar_len_i;
            r_size  <= bus.ar_size_i;
            r_burst <= bus.ar_burst_i;
            r_cnt   <= 8'd0;
            if (bus.aw_valid_i) begin
               r_prio_rd <= 1'b0;
            end
         end else if (w_aw_grant) begin
            r_id    <= bus.aw_id_i;
            r_addr  <= bus.aw_addr_i;
            r_len   <= bus.aw_len_i;
            r_size  <= bus.aw_size_i;
            r_burst <= bus.aw_burst_i;
            r_cnt   <= 8'd0;
            r_err   <= c_RESP_OKAY;
            if (bus.ar_valid_i) begin
               r_prio_rd <= 1'b1;
            end
         end
         // Beat registers only load when empty or consumed, which holds them stable under backpressure.
         if (r_state == S_RD) begin
            if (!r_rvalid || (w_r_hs && !r_rlast)) begin
               r_rvalid <= 1'b1;
               r_addr   <= w_beat_addr;
               r_cnt    <= w_beat_cnt;
               r_rdata  <= (w_beat_resp == c_RESP_OKAY) ? r_mem[w_idx] : '0;
               r_rresp  <= w_beat_resp;
               r_rlast  <= (w_beat_cnt == r_len);
            end else if (w_r_hs) begin
               r_rvalid <= 1'b0;
            end
         end
         if (w_w_hs) begin
            r_addr <= w_next_addr;
            r_cnt  <= r_cnt + 8'd1;
            if (w_wr_resp > r_err) begin
               r_err <= w_wr_resp;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_mem_we) begin
         for (int b = 0; b < c_LANES; b++) begin
            if (bus.w_strb_i[b]) begin
               r_mem[w_idx][b*8 +: 8] <= bus.w_data_i[b*8 +: 8];
            end
         end
      end
   end

   assign bus.ar_ready_o = w_ar_grant;
   assign bus.aw_ready_o = w_aw_grant;
   assign bus.w_ready_o  = w_w_ready;
   assign bus.b_valid_o  = w_b_valid;
   assign bus.b_id_o     = r_id;
   assign bus.b_resp_o   = r_err;
   assign bus.r_valid_o  = r_rvalid;
   assign bus.r_id_o     = r_id;
   assign bus.r_data_o   = r_rdata;
   assign bus.r_resp_o   = r_rresp;
   assign bus.r_last_o   = r_rlast;
endmodule
`default_nettype wire

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI4 subordinate (responder) backing a single-ported, word-addressed memory.
- Answers the core's AXI4 initiator: I/D-cache line refills, write-back evictions and uncached accesses.
- Used as DRAM or boot-ROM model in core-level simulation and FPGA bring-up.
- Serves one transaction at a time, either read or write, with INCR/FIXED bursts and address-range decode.

Parameters:
- IdWidth, 4, AXI ID width.
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width (fixed 64; 8 byte lanes).
- Depth, 1024, memory depth in 64-bit words (power of two).
- BaseAddr, 64'h8000_0000, first byte address served; range is [BaseAddr, BaseAddr+Depth*8).

Ports:
- clk_i in 1 clock
- rst_ni in 1 asynchronous active-low reset
- aw_valid_i in 1; aw_ready_o out 1; aw_id_i in IdWidth; aw_addr_i in AddrWidth; aw_len_i in 8; aw_size_i in 3; aw_burst_i in 2 — write address channel
- w_valid_i in 1; w_ready_o out 1; w_data_i in 64; w_strb_i in 8; w_last_i in 1 — write data channel
- b_valid_o out 1; b_ready_i in 1; b_id_o out IdWidth; b_resp_o out 2 — write response channel
- ar_valid_i in 1; ar_ready_o out 1; ar_id_i in IdWidth; ar_addr_i in AddrWidth; ar_len_i in 8; ar_size_i in 3; ar_burst_i in 2 — read address channel
- r_valid_o out 1; r_ready_i in 1; r_id_o out IdWidth; r_data_o out 64; r_resp_o out 2; r_last_o out 1 — read data channel

Behaviour:
- Reset (async assert, sync deassert via rst_ni):
  - FSM goes to IDLE; all valid/ready outputs 0; r_data_o, r_id_o, b_id_o, r_resp_o and b_resp_o are 0.
  - Priority flag favours read.
  - Memory contents are not reset.
  - Reset mid-burst abandons the transaction; no B or R is issued afterwards.
- FSM states: IDLE, RD, WR, WRESP.
- IDLE arbitration:
  - ar_ready_o = ar_valid_i && (!aw_valid_i || prio_rd).
  - aw_ready_o = aw_valid_i && (!ar_valid_i || !prio_rd).
  - Both AR and AW valid → the favoured one is granted and the priority flag toggles to the other. A single requester leaves the flag unchanged.
  - A handshake latches id, addr, len, size and burst, and clears the beat counter.
  - AR grant → RD; AW grant → WR.
- Address step per beat:
  - INCR: addr += (1<<size).
  - FIXED: address unchanged.
  - WRAP or reserved burst type: beats are still transferred, but the response is SLVERR (2'b10). Read data is 0 and writes are suppressed.
  - Memory index = (addr - BaseAddr) >> 3, truncated to log2(Depth) bits.
- Range check per beat: address outside the range → DECERR (2'b11) for that beat. Read data 0; write discarded.
- RD:
  - The memory read issues the cycle after the AR handshake; r_valid_o rises 2 cycles after the AR handshake cycle.
  - r_data_o, r_resp_o and r_last_o are stable while r_valid_o && !r_ready_i.
  - The next beat is presented the cycle after each r handshake (1-cycle bubble allowed; back-to-back is not required).
  - r_last_o=1 on beat len. Handshake of the last beat → IDLE.
- WR:
  - w_ready_o=1 in WR.
  - Each w handshake writes the bytes enabled by w_strb_i to the current word (if in range and the burst is legal), then advances the address and counter.
  - After beat len is accepted → WRESP.
  - w_last_i mismatch (asserted before beat len, or deasserted on beat len) → final response SLVERR; the beat count still governs completion.
- WRESP:
  - b_valid_o=1, b_id_o=latched id.
  - b_resp_o is the worst response seen in the burst: DECERR > SLVERR > OKAY.
  - Held until b_ready_i, then → IDLE.
- Read/write ordering: a write is fully committed to memory before its B is issued, so a read granted after that B observes the written data.
- W beats arriving while not in WR are not accepted (w_ready_o=0).

Test Plan:
- Single write/read: AW addr 0x8000_0010, len 0, size 3, data 0xDEAD_BEEF_0123_4567, strb 0xFF → B OKAY. Then AR to the same address → R data 0xDEAD_BEEF_0123_4567, OKAY, last=1, r_valid 2 cycles after the AR handshake.
- Cache line refill: INCR len 1 at 0x8000_0040 after writing words 0x11 and 0x22 → two R beats, 0x11 then 0x22, last only on beat 2. With r_ready held low for 3 cycles, the data stays stable.
- Byte strobes: write 0xFFFF..FF, then write 0x0 with strb 0x0F → read returns 0xFFFF_FFFF_0000_0000.
- Decode error: AR 0x0000_1000, len 3 → 4 beats, each data 0, resp DECERR, last on beat 4. Write to the same address → B DECERR, memory unchanged.
- Arbitration: AR and AW asserted in the same cycle after reset → read granted first, write granted next. Repeat the collision → write is granted first.
- Protocol errors: WRAP burst write → B SLVERR, no memory update. INCR len 1 with w_last on beat 1 → SLVERR, B issued after beat 2. Reset asserted mid-read → r_valid_o drops to 0 immediately.
